// File: rtl/manchester_frame_deframer_if.sv
// Bit-stream input and frame/byte output bundle for the Manchester deframer.
interface manchester_frame_deframer_if;
  logic       bit_strobe;
  logic       bit_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_start;
  logic       frame_done;
  logic       frame_err;
  logic       polarity_inv;
  logic       busy;

  modport master (
    output bit_strobe, bit_in,
    input  data_out, data_valid, frame_start, frame_done, frame_err, polarity_inv, busy
  );

  modport slave (
    input  bit_strobe, bit_in,
    output data_out, data_valid, frame_start, frame_done, frame_err, polarity_inv, busy
  );
endinterface

// File: rtl/manchester_frame_deframer.sv
// Sync hunt (either polarity), length-prefixed byte deframing and checksum check
// on a recovered bit stream. All outputs are registered.
module manchester_frame_deframer #(
  parameter logic [15:0] SYNC_WORD   = 16'hEB90,
  parameter int          MAX_LEN     = 64,
  parameter int          TIMEOUT_CYC = 20000
) (
  input logic                          clk,
  input logic                          rst,
  manchester_frame_deframer_if.slave   bus
);

  localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;

  state_t        state_q, state_d;
  logic [15:0]   sreg_q, sreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          pol_q, pol_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          fs_q, fs_d;
  logic          fd_q, fd_d;
  logic          fe_q, fe_d;
  logic          busy_q, busy_d;

  logic          strobe;
  logic          in_bit;
  logic [15:0]   shifted;
  logic [7:0]    byte_w;
  logic          last_bit;
  logic          timeout;
  logic          sync_hit;
  logic          sync_inv;
  logic          len_bad;
  logic          last_byte;

  // Shared decode of the incoming bit; HUNT looks at the raw line, framing at pbit.
  always_comb begin
    strobe    = bus.bit_strobe;
    in_bit    = (state_q == HUNT) ? bus.bit_in : (bus.bit_in ^ pol_q);
    shifted   = {sreg_q[14:0], in_bit};
    byte_w    = shifted[7:0];
    last_bit  = (bit_cnt_q == 3'd7);
    timeout   = (state_q != HUNT) && !strobe && (to_cnt_q == TO_LAST);
    sync_hit  = (shifted == SYNC_WORD);
    sync_inv  = (shifted == ~SYNC_WORD);
    len_bad   = (byte_w == 8'd0) || (byte_w > MAX_LEN_B);
    last_byte = ((byte_cnt_q + 8'd1) == len_q);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  // Next-state: advances only on strobes, except the inactivity abort.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = HUNT;
    end else if (strobe) begin
      case (state_q)
        HUNT:    if (sync_hit || sync_inv) state_d = LEN;
        LEN:     if (last_bit) state_d = len_bad ? HUNT : PAYLOAD;
        PAYLOAD: if (last_bit && last_byte) state_d = CHECK;
        CHECK:   if (last_bit) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Datapath and output next values.
  always_comb begin
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    csum_d     = csum_q;
    pol_d      = pol_q;
    data_d     = data_q;
    busy_d     = busy_q;
    dv_d       = 1'b0;
    fs_d       = 1'b0;
    fd_d       = 1'b0;
    fe_d       = 1'b0;
    to_cnt_d   = (state_q == HUNT || strobe) ? '0 : to_cnt_q + 1'b1;

    if (timeout) begin
      fd_d      = 1'b1;
      fe_d      = 1'b1;
      busy_d    = 1'b0;
      sreg_d    = '0;
      bit_cnt_d = '0;
      to_cnt_d  = '0;
    end else if (strobe) begin
      sreg_d = shifted;
      if (state_q != HUNT) bit_cnt_d = bit_cnt_q + 3'd1;
      case (state_q)
        HUNT: begin
          if (sync_hit || sync_inv) begin
            pol_d     = sync_inv;
            fs_d      = 1'b1;
            busy_d    = 1'b1;
            sreg_d    = '0;
            bit_cnt_d = '0;
          end
        end
        LEN: begin
          if (last_bit) begin
            if (len_bad) begin
              fd_d   = 1'b1;
              fe_d   = 1'b1;
              busy_d = 1'b0;
              sreg_d = '0;
            end else begin
              len_d      = byte_w;
              csum_d     = byte_w;
              byte_cnt_d = '0;
            end
          end
        end
        PAYLOAD: begin
          if (last_bit) begin
            data_d     = byte_w;
            dv_d       = 1'b1;
            csum_d     = csum_q + byte_w;
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
        CHECK: begin
          if (last_bit) begin
            fd_d   = 1'b1;
            fe_d   = (byte_w != csum_q);
            busy_d = 1'b0;
            sreg_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      to_cnt_q   <= '0;
      pol_q      <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      fe_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      to_cnt_q   <= to_cnt_d;
      pol_q      <= pol_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      fs_q       <= fs_d;
      fd_q       <= fd_d;
      fe_q       <= fe_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.data_out     = data_q;
  assign bus.data_valid   = dv_q;
  assign bus.frame_start  = fs_q;
  assign bus.frame_done   = fd_q;
  assign bus.frame_err    = fe_q;
  assign bus.polarity_inv = pol_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_manchester_frame_deframer.sv
// Randomized bench for the Manchester deframer against a frame-level reference model.
module tb_manchester_frame_deframer;
  localparam logic [15:0] SYNC = 16'hEB90;
  localparam int MAXL = 64;
  localparam int TO   = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  manchester_frame_deframer_if bus();

  manchester_frame_deframer #(.SYNC_WORD(SYNC), .MAX_LEN(MAXL), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int got_b[$], got_s[$], got_d[$];
  int exp_b[$], exp_s[$], exp_d[$];
  bit stream[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (bus.data_valid)  got_b.push_back(int'(bus.data_out));
      if (bus.frame_start) got_s.push_back(int'(bus.polarity_inv));
      if (bus.frame_done)  got_d.push_back(int'(bus.frame_err));
    end
  end

  // Reference: reads the bit list as sync / length / payload / checksum fields.
  function automatic int get_byte(int i, bit pol);
    int v = 0;
    for (int k = 0; k < 8; k++) v = (v << 1) | int'(stream[i+k] ^ pol);
    return v;
  endfunction

  task automatic model();
    int i = 0;
    int n = stream.size();
    logic [15:0] win = '0;
    bit pol;
    int len, sum, b, c;
    bit ok;
    while (i < n) begin
      win = {win[14:0], stream[i]};
      i++;
      if (win == SYNC || win == ~SYNC) begin
        pol = (win != SYNC);
        exp_s.push_back(int'(pol));
        win = '0;
        if (i + 8 > n) break;
        len = get_byte(i, pol); i += 8;
        if (len == 0 || len > MAXL) begin
          exp_d.push_back(1);
          continue;
        end
        sum = len; ok = 1'b1;
        for (int k = 0; k < len; k++) begin
          if (i + 8 > n) begin ok = 1'b0; break; end
          b = get_byte(i, pol); i += 8;
          exp_b.push_back(b);
          sum = (sum + b) % 256;
        end
        if (!ok || i + 8 > n) break;
        c = get_byte(i, pol); i += 8;
        exp_d.push_back(int'(c != sum));
      end
    end
  endtask

  task automatic push_byte(input int b, input bit inv);
    for (int k = 7; k >= 0; k--) stream.push_back(b[k] ^ inv);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) stream.push_back(1'($urandom));
  endtask

  task automatic push_frame(input int len, input bit inv, input bit good);
    int sum = len;
    int b;
    push_byte(int'(SYNC[15:8]), inv);
    push_byte(int'(SYNC[7:0]), inv);
    push_byte(len, inv);
    if (len == 0 || len > MAXL) return;
    for (int k = 0; k < len; k++) begin
      b = int'($urandom_range(0, 255));
      push_byte(b, inv);
      sum = (sum + b) % 256;
    end
    push_byte(good ? sum : (sum + 1) % 256, inv);
  endtask

  task automatic send_bit(input bit b, input int gap);
    @(negedge clk);
    bus.bit_in = b;
    bus.bit_strobe = 1'b1;
    @(negedge clk);
    bus.bit_strobe = 1'b0;
    bus.bit_in = 1'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.bit_strobe = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_b.delete(); got_s.delete(); got_d.delete();
    exp_b.delete(); exp_s.delete(); exp_d.delete();
    stream.delete();
  endtask

  task automatic run_cmp(input string tag);
    model();
    foreach (stream[i]) send_bit(stream[i], int'($urandom_range(0, 2)));
    repeat (20) @(negedge clk);
    chk($sformatf("%s n_start", tag), got_s.size(), exp_s.size());
    chk($sformatf("%s n_byte", tag), got_b.size(), exp_b.size());
    chk($sformatf("%s n_done", tag), got_d.size(), exp_d.size());
    for (int i = 0; i < exp_s.size() && i < got_s.size(); i++)
      chk($sformatf("%s pol[%0d]", tag, i), got_s[i], exp_s[i]);
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      chk($sformatf("%s byte[%0d]", tag, i), got_b[i], exp_b[i]);
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
      chk($sformatf("%s err[%0d]", tag, i), got_d[i], exp_d[i]);
  endtask

  task automatic push_t2(input bit inv, input int cs);
    push_byte('hEB, inv); push_byte('h90, inv); push_byte('h03, inv);
    push_byte('h11, inv); push_byte('h22, inv); push_byte('h33, inv);
    push_byte(cs, inv);
  endtask

  initial begin
    int n_seen;
    int r, len;
    logic [15:0] sw;
    bus.bit_strobe = 1'b0;
    bus.bit_in = 1'b0;

    // 1: reset held while bits (including a sync word) stream in
    rst = 1'b1;
    sw = SYNC;
    for (int i = 0; i < 16; i++) begin
      send_bit(sw[15-i], 0);
      chk("rst outs", int'({bus.data_out, bus.data_valid, bus.frame_start, bus.frame_done,
                            bus.frame_err, bus.polarity_inv, bus.busy}), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst busy", int'(bus.busy), 0);

    // 2: good frame, normal polarity
    do_reset();
    push_t2(1'b0, 'h69);
    run_cmp("t2");
    chk("t2 byte0", got_b.size() > 0 ? got_b[0] : -1, 'h11);
    chk("t2 byte2", got_b.size() > 2 ? got_b[2] : -1, 'h33);
    chk("t2 err", got_d.size() > 0 ? got_d[0] : -1, 0);
    chk("t2 pol", int'(bus.polarity_inv), 0);
    chk("t2 busy", int'(bus.busy), 0);

    // 3: inverted line
    do_reset();
    push_t2(1'b1, 'h69);
    run_cmp("t3");
    chk("t3 pol", int'(bus.polarity_inv), 1);
    chk("t3 err", got_d.size() > 0 ? got_d[0] : -1, 0);

    // 4: bad checksum
    do_reset();
    push_t2(1'b0, 'h6A);
    run_cmp("t4");
    chk("t4 err", got_d.size() > 0 ? got_d[0] : -1, 1);

    // 5: illegal lengths, each followed by a good frame
    do_reset();
    push_frame(0, 1'b0, 1'b1);
    push_frame(3, 1'b0, 1'b1);
    run_cmp("t5a");
    chk("t5a err0", got_d.size() > 0 ? got_d[0] : -1, 1);
    do_reset();
    push_frame(MAXL + 1, 1'b1, 1'b1);
    push_frame(2, 1'b1, 1'b1);
    run_cmp("t5b");
    chk("t5b err0", got_d.size() > 0 ? got_d[0] : -1, 1);
    chk("t5b bytes", got_b.size(), 2);

    // 6a: strobes stop after first payload byte -> abort exactly TO clks later
    do_reset();
    push_byte('hEB, 1'b0); push_byte('h90, 1'b0); push_byte('h03, 1'b0); push_byte('h11, 1'b0);
    for (int i = 0; i < stream.size() - 1; i++) send_bit(stream[i], 1);
    @(negedge clk);
    bus.bit_in = stream[stream.size()-1];
    bus.bit_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bit_strobe = 1'b0;
    n_seen = -1;
    for (int n = 1; n <= TO + 50; n++) begin
      @(posedge clk);
      #1;
      if (bus.frame_done) begin
        n_seen = n;
        chk("t6 to err", int'(bus.frame_err), 1);
        break;
      end
    end
    chk("t6 to latency", n_seen, TO);
    chk("t6 to bytes", got_b.size(), 1);
    @(negedge clk);
    chk("t6 to busy", int'(bus.busy), 0);

    // 6b: reset mid-payload
    do_reset();
    push_byte('hEB, 1'b0); push_byte('h90, 1'b0); push_byte('h03, 1'b0); push_byte('h11, 1'b0);
    push_idle(4);
    foreach (stream[i]) send_bit(stream[i], 1);
    chk("t6 rst busy pre", int'(bus.busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6 rst busy", int'(bus.busy), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t6 rst no done", got_d.size(), 0);

    // random frames
    for (int it = 0; it < 25; it++) begin
      do_reset();
      push_idle(int'($urandom_range(0, 20)));
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      len = 0;
        else if (r == 1) len = int'($urandom_range(MAXL + 1, 255));
        else if (r == 2) len = MAXL;
        else             len = int'($urandom_range(1, 8));
        push_frame(len, 1'($urandom), ($urandom_range(0, 3) != 0));
        push_idle(int'($urandom_range(0, 12)));
      end
      run_cmp($sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
